pmem_scheduler: RTL and testbench

PMEM_SCHEDULER -- requirements
Module: pmem_scheduler

---
 rtl/lc3b_types.sv | 16 +
 rtl/starve_counter.sv | 35 +++
 rtl/pmem_scheduler.sv | 115 +++++++++++
 tb/tb_pmem_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared types for the pmem scheduler
package lc3b_types;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_RD    = 3'd1,
        D_RD    = 3'd2,
        D_WR    = 3'd3,
        RECOVER = 3'd4
    } pmem_sched_state_t;

    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - counts D grants made while I waits
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_inc       : a D grant happened while I was requesting
//   i_clr       : an I grant happened
//   o_at_limit  : count has reached LIMIT
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_count;

    assign o_at_limit = (r_count == W'(LIMIT));

    // Saturates at LIMIT so the count can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/pmem_scheduler.sv
// rtl/pmem_scheduler.sv - arbitrates I-cache and D-cache line requests onto pmem
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   icache_pmem_read/address        : I-cache line read request
//   dcache_pmem_read/write/address/wdata : D-cache line request
//   icache_mem_resp/rdata           : I completion and line data
//   dcache_mem_resp/rdata           : D completion and line data
//   pmem_read/write/address/wdata   : physical memory request
//   pmem_resp/rdata                 : physical memory completion and data
//
// Build option: PMEM_SCHED_STARVE_GUARD_EN adds a starvation guard that forces
// an I grant after STARVE_LIMIT consecutive D grants while I is waiting.
module pmem_scheduler
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        icache_pmem_read,
    input  logic [15:0] icache_pmem_address,
    input  logic        dcache_pmem_read,
    input  logic        dcache_pmem_write,
    input  logic [15:0] dcache_pmem_address,
    input  lc3b_line    dcache_pmem_wdata,
    output logic        icache_mem_resp,
    output lc3b_line    icache_mem_rdata,
    output logic        dcache_mem_resp,
    output lc3b_line    dcache_mem_rdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output lc3b_line    pmem_wdata,
    input  logic        pmem_resp,
    input  lc3b_line    pmem_rdata
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    pmem_sched_state_t r_state;
    pmem_sched_state_t w_next;
    logic [15:0]       r_address;
    lc3b_line          r_wdata;
    logic              w_grant;
    logic              w_force_i;

`ifdef PMEM_SCHED_STARVE_GUARD_EN
    logic w_at_limit;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (w_grant && (w_next == D_RD || w_next == D_WR) && icache_pmem_read),
        .i_clr      (w_grant && (w_next == I_RD)),
        .o_at_limit (w_at_limit)
    );

    assign w_force_i = w_at_limit && icache_pmem_read;
`else
    assign w_force_i = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                // A write wins over a read when the D-cache raises both.
                if (w_force_i)               w_next = I_RD;
                else if (dcache_pmem_write)  w_next = D_WR;
                else if (dcache_pmem_read)   w_next = D_RD;
                else if (icache_pmem_read)   w_next = I_RD;
            end
            I_RD, D_RD, D_WR: begin
                if (pmem_resp) w_next = RECOVER;
            end
            // One dead cycle lets the requester drop its request before
            // IDLE samples it again.
            RECOVER: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_grant = (r_state == IDLE) && (w_next != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_address <= '0;
            r_wdata   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_address <= (w_next == I_RD) ? icache_pmem_address : dcache_pmem_address;
            end
            if (w_grant && (w_next == D_WR)) begin
                r_wdata <= dcache_pmem_wdata;
            end
        end
    end

    assign pmem_read       = (r_state == I_RD) || (r_state == D_RD);
    assign pmem_write      = (r_state == D_WR);
    assign pmem_address    = r_address;
    assign pmem_wdata      = r_wdata;
    assign icache_mem_resp = (r_state == I_RD) && pmem_resp;
    assign dcache_mem_resp = ((r_state == D_RD) || (r_state == D_WR)) && pmem_resp;
    assign icache_mem_rdata = pmem_rdata;
    assign dcache_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_scheduler.sv
// tb/tb_pmem_scheduler.sv - directed self-checking bench for pmem_scheduler
module tb_pmem_scheduler;

    logic         clk;
    logic         reset;
    logic         icache_pmem_read;
    logic [15:0]  icache_pmem_address;
    logic         dcache_pmem_read;
    logic         dcache_pmem_write;
    logic [15:0]  dcache_pmem_address;
    logic [127:0] dcache_pmem_wdata;
    logic         icache_mem_resp;
    logic [127:0] icache_mem_rdata;
    logic         dcache_mem_resp;
    logic [127:0] dcache_mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    int checks;
    int errors;

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] LINE_W  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    pmem_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_address (icache_pmem_address),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .icache_mem_resp     (icache_mem_resp),
        .icache_mem_rdata    (icache_mem_rdata),
        .dcache_mem_resp     (dcache_mem_resp),
        .dcache_mem_rdata    (dcache_mem_rdata),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_address        (pmem_address),
        .pmem_wdata          (pmem_wdata),
        .pmem_resp           (pmem_resp),
        .pmem_rdata          (pmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next cycle; inputs are driven 1 ns after the edge and
    // outputs are sampled on the following falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        icache_pmem_read = 1'b0; icache_pmem_address = '0;
        dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
        dcache_pmem_address = '0; dcache_pmem_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        tick(); tick();
        sample();
        checks++;
        if ({pmem_read, pmem_write, icache_mem_resp, dcache_mem_resp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {pmem_read, pmem_write, icache_mem_resp, dcache_mem_resp});
        end
        checks++;
        if (pmem_address !== 16'h0000 || pmem_wdata !== 128'h0) begin
            errors++;
            $display("FAIL reset_regs: addr %h wdata %h expected 0", pmem_address, pmem_wdata);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_i_read();
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h1230;
        sample();
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++; $display("FAIL i_read_t0: pmem_read %b expected 0", pmem_read);
        end
        tick();
        icache_pmem_address = 16'hFFFF;   // change after grant must not matter
        sample();
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230) begin
            errors++;
            $display("FAIL i_read_t1: rd %b wr %b addr %h expected 1 0 1230",
                     pmem_read, pmem_write, pmem_address);
        end
        tick(); tick();
        pmem_resp = 1'b1; pmem_rdata = LINE_A5;
        sample();
        checks++;
        if (icache_mem_resp !== 1'b1 || dcache_mem_resp !== 1'b0 ||
            icache_mem_rdata !== LINE_A5 || pmem_address !== 16'h1230) begin
            errors++;
            $display("FAIL i_read_resp: iresp %b dresp %b rdata %h addr %h expected 1 0 a5.. 1230",
                     icache_mem_resp, dcache_mem_resp, icache_mem_rdata, pmem_address);
        end
        tick();
        pmem_resp = 1'b0; icache_pmem_read = 1'b0;
        sample();
        checks++;
        if (icache_mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL i_read_after: iresp %b rd %b expected 0 0", icache_mem_resp, pmem_read);
        end
        tick();
    endtask

    task automatic test_priority();
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h0040;
        dcache_pmem_write = 1'b1; dcache_pmem_address = 16'h8000; dcache_pmem_wdata = LINE_W;
        tick();
        sample();
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h8000 ||
            pmem_wdata !== LINE_W) begin
            errors++;
            $display("FAIL prio_d_first: wr %b rd %b addr %h wdata %h expected 1 0 8000 %h",
                     pmem_write, pmem_read, pmem_address, pmem_wdata, LINE_W);
        end
        tick();
        pmem_resp = 1'b1;
        sample();
        checks++;
        if (dcache_mem_resp !== 1'b1 || icache_mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL prio_d_resp: dresp %b iresp %b expected 1 0", dcache_mem_resp, icache_mem_resp);
        end
        tick();
        pmem_resp = 1'b0; dcache_pmem_write = 1'b0;
        sample();
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++; $display("FAIL prio_recover: rd %b wr %b expected 0 0", pmem_read, pmem_write);
        end
        tick();
        sample();
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++; $display("FAIL prio_idle: rd %b expected 0", pmem_read);
        end
        tick();
        sample();
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h0040) begin
            errors++;
            $display("FAIL prio_i_issue: rd %b addr %h expected 1 0040", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; icache_pmem_read = 1'b0;
        tick();
    endtask

    task automatic test_read_write_both();
        dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1; dcache_pmem_address = 16'h0100;
        tick();
        sample();
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h0100) begin
            errors++;
            $display("FAIL rw_both: wr %b rd %b addr %h expected 1 0 0100",
                     pmem_write, pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h0200;
        tick();
        sample();
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++; $display("FAIL rst_mid_busy: rd %b expected 1", pmem_read);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; dcache_pmem_read = 1'b0; pmem_resp = 1'b1;
        sample();
        checks++;
        if ({dcache_mem_resp, icache_mem_resp, pmem_read, pmem_write} !== 4'b0000 ||
            pmem_address !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_stray: dresp %b iresp %b rd %b wr %b addr %h expected 0 0 0 0 0000",
                     dcache_mem_resp, icache_mem_resp, pmem_read, pmem_write, pmem_address);
        end
        tick();
        pmem_resp = 1'b0;
        sample();
        checks++;
        if ({dcache_mem_resp, pmem_read, pmem_write} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_after: dresp %b rd %b wr %b expected 000",
                     dcache_mem_resp, pmem_read, pmem_write);
        end
        // Still IDLE: a new request must strobe on the very next cycle.
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h0300;
        tick();
        sample();
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h0300) begin
            errors++;
            $display("FAIL rst_mid_idle: rd %b addr %h expected 1 0300", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; icache_pmem_read = 1'b0;
        tick();
    endtask

    task automatic test_idle_resp();
        pmem_resp = 1'b1;
        sample();
        checks++;
        if ({icache_mem_resp, dcache_mem_resp, pmem_read, pmem_write} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_resp: got %b expected 0000",
                     {icache_mem_resp, dcache_mem_resp, pmem_read, pmem_write});
        end
        tick();
        pmem_resp = 1'b0;
        dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h0700;
        tick();
        sample();
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h0700) begin
            errors++;
            $display("FAIL idle_resp_grant: rd %b addr %h expected 1 0700", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        tick();
        dcache_pmem_read = 1'b0;   // pmem_resp still high during RECOVER
        sample();
        checks++;
        if (dcache_mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL recover_resp: dresp %b rd %b expected 0 0", dcache_mem_resp, pmem_read);
        end
        tick();
        pmem_resp = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back_starve();
        logic [15:0] exp_addr;
        dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h3000;
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h0050;
        for (int g = 1; g <= 6; g++) begin
            exp_addr = 16'h3000;
`ifdef PMEM_SCHED_STARVE_GUARD_EN
            if (g == 5) exp_addr = 16'h0050;
`endif
            tick();
            pmem_resp = 1'b1;
            sample();
            checks++;
            if (pmem_read !== 1'b1 || pmem_address !== exp_addr ||
                icache_mem_resp !== (exp_addr == 16'h0050) ||
                dcache_mem_resp !== (exp_addr == 16'h3000)) begin
                errors++;
                $display("FAIL b2b_grant%0d: rd %b addr %h iresp %b dresp %b expected addr %h",
                         g, pmem_read, pmem_address, icache_mem_resp, dcache_mem_resp, exp_addr);
            end
            tick();
            pmem_resp = 1'b0;
            sample();
            checks++;
            if (pmem_read !== 1'b0) begin
                errors++; $display("FAIL b2b_recover%0d: rd %b expected 0", g, pmem_read);
            end
            tick();
        end
        dcache_pmem_read = 1'b0;
        tick();
        sample();
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h0050) begin
            errors++;
            $display("FAIL b2b_i_after_d: rd %b addr %h expected 1 0050", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; icache_pmem_read = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_i_read();
        test_priority();
        test_read_write_both();
        test_reset_mid();
        test_idle_resp();
        test_back_to_back_starve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
